// File: rtl/game_pkg.sv
// game_pkg: step-mode encodings, FSM state and result codes shared by the game blocks
package game_pkg;
  localparam logic [2:0] CTRL_INC1 = 3'b000;
  localparam logic [2:0] CTRL_INC2 = 3'b001;
  localparam logic [2:0] CTRL_INC4 = 3'b100;
  localparam logic [2:0] CTRL_DEC1 = 3'b010;
  localparam logic [2:0] CTRL_DEC2 = 3'b011;
  localparam logic [2:0] CTRL_DEC4 = 3'b101;
  localparam logic [1:0] WHO_NONE  = 2'b00;
  localparam logic [1:0] WHO_LOSE  = 2'b01;
  localparam logic [1:0] WHO_WIN   = 2'b10;
  typedef enum logic {PLAY, OVER} state_e;
endpackage

// File: rtl/game_score_counter.sv
// game_score_counter: per-game score with clear; flags the increment that reaches TARGET
module game_score_counter #(
  parameter int TARGET = 15,
  parameter int SW = $clog2(TARGET + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          clr,
  output logic [SW-1:0] score,
  output logic          hit_target
);
  logic [SW-1:0] score_q;
  assign score = score_q;
  assign hit_target = inc && score_q == SW'(TARGET - 1);
  always_ff @(posedge clk)
    if (!rst || clr) score_q <= '0;
    else if (inc) score_q <= score_q + 1'b1;
endmodule

// File: rtl/multi_mode_game.sv
// multi_mode_game: multi-step play counter with win/loss scoring and a timed game-over hold
module multi_mode_game
  import game_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int TARGET = 15,
  parameter int HOLD_CYCLES = 4,
  localparam int SW = $clog2(TARGET + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       ctrl,
  input  logic [WIDTH-1:0] init_val,
  input  logic             init,
  output logic [WIDTH-1:0] count,
  output logic             winner,
  output logic             loser,
  output logic [SW-1:0]    win_score,
  output logic [SW-1:0]    lose_score,
  output logic             gameover,
  output logic [1:0]       who
);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  state_e state_q;
  logic [WIDTH-1:0] count_q, count_d, step;
  logic [HW-1:0] hold_q;
  logic [2:0] mag;
  logic [1:0] who_q;
  logic winner_q, loser_q, gameover_q, dn, mv, play_step, win_hit, lose_hit, win_tgt, lose_tgt, done;
  always_comb begin
    mv = !(ctrl[2] && ctrl[1]);
    dn = ctrl inside {CTRL_DEC1, CTRL_DEC2, CTRL_DEC4};
    mag = ctrl[2] ? (ctrl[1] ? 3'd0 : 3'd4) : (ctrl[0] ? 3'd2 : 3'd1);
    step = WIDTH'(mag);
    count_d = dn ? count_q - step : count_q + step;
    play_step = state_q == PLAY && !init && mv;
    win_hit = play_step && count_d == '1;
    lose_hit = play_step && count_d == '0;
    done = state_q == OVER && hold_q == HW'(HOLD_CYCLES - 1);
  end
  game_score_counter #(.TARGET(TARGET), .SW(SW)) u_win (
    .clk(clk), .rst(rst), .inc(win_hit), .clr(done), .score(win_score), .hit_target(win_tgt)
  );
  game_score_counter #(.TARGET(TARGET), .SW(SW)) u_lose (
    .clk(clk), .rst(rst), .inc(lose_hit), .clr(done), .score(lose_score), .hit_target(lose_tgt)
  );
  always_ff @(posedge clk)
    if (!rst) begin
      state_q <= PLAY;
      count_q <= '0;
      hold_q <= '0;
      winner_q <= 1'b0;
      loser_q <= 1'b0;
      gameover_q <= 1'b0;
      who_q <= WHO_NONE;
    end else if (state_q == PLAY) begin
      winner_q <= win_hit;
      loser_q <= lose_hit;
      count_q <= init ? init_val : count_d;
      hold_q <= '0;
      if (win_tgt || lose_tgt) begin
        state_q <= OVER;
        gameover_q <= 1'b1;
        who_q <= win_tgt ? WHO_WIN : WHO_LOSE;
      end
    end else begin
      winner_q <= 1'b0;
      loser_q <= 1'b0;
      hold_q <= hold_q + 1'b1;
      if (done) begin
        state_q <= PLAY;
        count_q <= '0;
        hold_q <= '0;
        gameover_q <= 1'b0;
        who_q <= WHO_NONE;
      end
    end
  assign count = count_q;
  assign winner = winner_q;
  assign loser = loser_q;
  assign gameover = gameover_q;
  assign who = who_q;
endmodule

// File: doc/multi_mode_game.md
# multi_mode_game

Parametrised successor of the counter game. A WIDTH-bit play counter steps up or down by 1, 2 or 4, or holds, under a 3-bit mode input. Hitting all-ones scores a win and hitting zero scores a loss. When either score reaches TARGET, the block holds a game-over indication for HOLD_CYCLES cycles, then clears itself and resumes play. It sits between the player control inputs and the display/status logic.

## Interface
- WIDTH, 4, play counter width (≥2)
- TARGET, 15, score that ends a game (≥1)
- HOLD_CYCLES, 4, cycles the game-over state is held (≥1)
- SW = $clog2(TARGET+1), derived score width (localparam)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-low; takes effect at the rising edge of clk while rst=0
- ctrl  in  3  step mode (see Operation)
- init_val  in  WIDTH  counter load value
- init  in  1  load init_val into counter this cycle
- count  out  WIDTH  current play counter
- winner  out  1  one-cycle pulse: step landed on all-ones
- loser  out  1  one-cycle pulse: step landed on zero
- win_score  out  SW  wins in current game
- lose_score  out  SW  losses in current game
- gameover  out  1  high throughout OVER state
- who  out  2  2'b10 winner, 2'b01 loser, 2'b00 no result; valid while gameover=1

## Operation
- ctrl encoding:
  - 000 +1, 001 +2, 100 +4
  - 010 −1, 011 −2, 101 −4
  - 110/111 hold (step 0)
- Arithmetic: modulo 2^WIDTH; wrap both ways, no saturation.
- States: PLAY, OVER. Reset → PLAY.
- In PLAY, precedence is init over step:
  - init=1: count←init_val. No hit detection and no score change this cycle.
  - init=0: next=count+step, count←next.
  - winner←(next==all-ones and step≠0).
  - loser←(next==0 and step≠0).
  - Matching score increments on the same edge.
- Hold mode produces no pulses, even if count already sits at 0 or all-ones.
- Game end: if an increment makes a score equal TARGET, on the same edge:
  - go to OVER;
  - gameover←1;
  - who←10 (win_score hit TARGET) or 01 (lose_score hit TARGET).
  - Only one score can increment per cycle, so a simultaneous end cannot occur.
- In OVER: count and scores frozen; init and ctrl ignored. Hold counter runs HOLD_CYCLES cycles.
- OVER exit, on one edge: count←0, scores←0, gameover←0, who←00, state←PLAY. No pulse on this edge.
- winner/loser are 0 in every cycle that is not a PLAY step.
- Reset values (all outputs): count 0, winner 0, loser 0, win_score 0, lose_score 0, gameover 0, who 00. Hold counter 0, state PLAY.
- Reset mid-game or mid-OVER: immediate return to reset values; in-progress game discarded.

## Timing
- All outputs are registered; there is no combinational path from input to output.
- Step latency: ctrl/init sampled at edge N, count valid after edge N.
- winner/loser/score update coincides with that count update.
- Final score increment, gameover=1 and who become visible after the same edge.
- gameover stays high for exactly HOLD_CYCLES cycles. The first PLAY step after it is sampled at the next edge.
- init asserted on the edge that exits OVER is ignored.

## Structure
- Package game_pkg:
  - ctrl encoding constants;
  - state enum {PLAY, OVER};
  - who constants WHO_NONE/WHO_LOSE/WHO_WIN.
- Sub-module game_score_counter (SW-bit, inputs inc/clr, output hit_target), instantiated twice (win, loss).
- Top holds the play counter, step decode, FSM and hold counter.

## Test plan
- Reset: hold rst=0 two cycles with init=1, ctrl=001 → all outputs reset values. count stays 0 while rst=0.
- Up/wrap (WIDTH 4): init_val=8, then ctrl=000 → count 9..15; winner pulse at 15, win_score=1. Next step gives count 0, loser pulse, lose_score=1.
- Down by 2: init_val=14, ctrl=011 → 12,10,…,0 after 7 steps; loser pulse; then 14. Never winner.
- Hold and init: ctrl=110 at count=0 → no pulses for 10 cycles. init=1, init_val=15 → count 15 with no winner pulse.
- Game over (TARGET 15, HOLD 4): ctrl=101 from 0 → loser every 4th cycle. 15th loss gives gameover=1, who=01 for 4 cycles, with init/ctrl ignored. Then all cleared and play resumes.
- Reset mid-OVER: rst=0 on 2nd OVER cycle → next cycle gameover=0, who=00, scores 0, count 0.
